dct_block_ctrl: RTL and testbench
=================================

DCT_BLOCK_CTRL -- requirements
Module: dct_block_ctrl

Interface
REQ-001 Parameter LINE_W, default 256: pixels per image line; the only supported value.
REQ-002 Parameter BLK, default 8: block edge; equals the number of line buffers.
REQ-003 i_clk  input  1  clock; all logic rising-edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_pix  input  8  raster-order pixel.
REQ-006 i_pix_valid  input  1  i_pix valid; accepted when o_in_ready=1.
REQ-007 o_in_ready  output  1  block can accept a pixel this cycle.
REQ-008 o_block  output  512  8x8 block; row r at [64r+63:64r], column c of that row at [8c+7:8c] within the row.
REQ-009 o_blk_valid  output  1  o_block valid.
REQ-010 i_blk_ready  input  1  downstream accepts; transfer = o_blk_valid & i_blk_ready.
REQ-011 o_blk_idx  output  5  horizontal block index 0..31 within the current band.
REQ-012 o_blk_last  output  1  high with the block whose o_blk_idx = 31.

Function
REQ-013 The block SHALL have two states: FILL and DRAIN.
REQ-014 FILL: o_in_ready=1, o_blk_valid=0.
REQ-015 DRAIN: o_in_ready=0, o_blk_valid=1.
REQ-016 Each accepted pixel SHALL be written to line buffer line_cnt (0..7) at column col_cnt (0..255).
REQ-017 col_cnt SHALL increment per accepted pixel and wrap 255->0.
REQ-018 line_cnt SHALL increment on that wrap.
REQ-019 Cycles with i_pix_valid=0 SHALL advance no counter and write nothing.
REQ-020 Acceptance of pixel (line 7, col 255) SHALL move FILL->DRAIN; o_blk_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-021 In DRAIN, o_block row r SHALL equal pixels 8k..8k+7 of band line r, with k = o_blk_idx.
REQ-022 Each transfer SHALL advance the read position of all 8 line buffers by 8 pixels in the same cycle and increment o_blk_idx.
REQ-023 The transfer with o_blk_idx=31 SHALL move DRAIN->FILL, with o_blk_idx, col_cnt and line_cnt all 0.
REQ-024 o_in_ready SHALL be 1 on the following cycle.
REQ-025 With i_blk_ready=0, o_block, o_blk_idx and o_blk_last SHALL hold stable.
REQ-026 i_pix_valid in DRAIN SHALL be ignored; no write occurs.
REQ-027 Line-buffer write and read positions SHALL wrap naturally modulo 256 at band boundaries; no explicit pointer clear is needed between bands.
REQ-028 Throughput: one band = 2048 accepted pixels followed by at least 32 DRAIN cycles.
REQ-029 o_blk_last SHALL equal (o_blk_idx==31) & o_blk_valid.

Reset
REQ-030 i_rst SHALL force state FILL and clear col_cnt, line_cnt and o_blk_idx.
REQ-031 i_rst SHALL be propagated to all line buffers, clearing their pointers.
REQ-032 During i_rst, o_in_ready, o_blk_valid and o_blk_last SHALL be 0.
REQ-033 o_in_ready SHALL be 1 on the first cycle after i_rst deasserts.
REQ-034 Reset mid-FILL or mid-DRAIN SHALL discard the partial band; the next accepted pixel is line 0, col 0.

Structure
REQ-035 LINE_W, BLK, block-index width (5) and col width (8) SHALL be constants in the shared DCT package.
REQ-036 Eight instances of the existing line-buffer sub-module SHALL be used, with this contract:
- 256x8 storage;
- write at its write pointer on data-valid, pointer +1 per write;
- 64-bit combinational output of 8 pixels at its read pointer;
- read pointer +8 per read strobe;
- synchronous reset.
REQ-037 Write-enable SHALL be one-hot decoded from line_cnt.
REQ-038 The read strobe SHALL be the common transfer signal.
REQ-039 o_block SHALL be the concatenation of the 8 line-buffer outputs, with no extra register stage.

Verification
REQ-040 Reset scenario: hold i_rst 3 cycles, then release -> o_in_ready=1, o_blk_valid=0, o_blk_idx=0.
REQ-041 Full-band scenario: feed 2048 pixels, pixel = {line[2:0], col[7:3]}, i_blk_ready=1.
- Expect o_blk_valid the cycle after the last pixel.
- Expect 32 consecutive blocks.
- In block k, every byte of row r = 32r+k; block 5 row 3 = 0x65 in every byte.
- o_blk_last high only on k=31.
REQ-042 Backpressure scenario: in DRAIN at o_blk_idx=4, drop i_blk_ready for 10 cycles.
- o_block and o_blk_idx stay constant.
- After release, block 5 follows with the correct data.
REQ-043 Bubble scenario: feed pixels with i_pix_valid toggling 1/0 every cycle, and assert i_pix_valid throughout DRAIN.
- Block contents match REQ-041.
- No DRAIN-time write corrupts the data.
- Two back-to-back bands both give correct data.
REQ-044 Mid-DRAIN reset scenario: assert i_rst at o_blk_idx=10, then feed a new band with pixel = 0xA5.
- First block after refill has idx 0 and all bytes 0xA5.

Source files
------------

// File: rtl/dct_block_ctrl_pkg.sv
// Shared constants and types for the DCT 8x8 block former.
package dct_block_ctrl_pkg;

    localparam int LINE_W     = 256;
    localparam int BLK        = 8;
    localparam int PIX_W      = 8;
    localparam int IDX_W      = 5;
    localparam int COL_W      = 8;
    localparam int LINE_CNT_W = 3;
    localparam int ROW_W      = BLK * PIX_W;
    localparam int BLOCK_W    = BLK * ROW_W;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/dct_block_ctrl_if.sv
// Pixel-in / block-out handshake bundle; the block former sits on the slave side.
interface dct_block_ctrl_if;
    import dct_block_ctrl_pkg::*;

    logic [PIX_W-1:0]   i_pix;
    logic               i_pix_valid;
    logic               o_in_ready;
    logic [BLOCK_W-1:0] o_block;
    logic               o_blk_valid;
    logic               i_blk_ready;
    logic [IDX_W-1:0]   o_blk_idx;
    logic               o_blk_last;

    modport master (
        output i_pix, i_pix_valid, i_blk_ready,
        input  o_in_ready, o_block, o_blk_valid, o_blk_idx, o_blk_last
    );

    modport slave (
        input  i_pix, i_pix_valid, i_blk_ready,
        output o_in_ready, o_block, o_blk_valid, o_blk_idx, o_blk_last
    );

endinterface

// File: rtl/dct_block_ctrl_line_buf.sv
// One image line of storage: sequential pixel writes, 8-pixel-wide combinational reads.
module dct_block_ctrl_line_buf
    import dct_block_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [ROW_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [LINE_W];
    logic [COL_W-1:0] wr_ptr;
    logic [COL_W-1:0] rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + COL_W'(BLK);
        end
    end

    // NOTE: the storage array is deliberately not reset; it is always written before it is read.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < BLK; c++) begin
            rd_data[c*PIX_W +: PIX_W] = mem[rd_ptr + COL_W'(c)];
        end
    end

endmodule

// File: rtl/dct_block_ctrl.sv
// Gathers a band of 8 raster lines into line buffers, then emits 32 8x8 blocks.
module dct_block_ctrl #(
    parameter int LINE_W = dct_block_ctrl_pkg::LINE_W,
    parameter int BLK    = dct_block_ctrl_pkg::BLK
) (
    input  logic             i_clk,
    input  logic             i_rst,
    dct_block_ctrl_if.slave  bus
);
    import dct_block_ctrl_pkg::*;

    state_t                  state_q, state_d;
    logic [COL_W-1:0]        col_cnt;
    logic [LINE_CNT_W-1:0]   line_cnt;
    logic [IDX_W-1:0]        blk_idx;
    logic                    accept, xfer, last_col, last_pix, last_blk;
    logic [BLK-1:0]          wr_en;
    logic [ROW_W-1:0]        rows [BLK];

    assign accept   = (state_q == ST_FILL)  && bus.i_pix_valid;
    assign xfer     = (state_q == ST_DRAIN) && bus.i_blk_ready;
    assign last_col = (col_cnt == COL_W'(LINE_W - 1));
    assign last_pix = last_col && (line_cnt == LINE_CNT_W'(BLK - 1));
    assign last_blk = (blk_idx == IDX_W'(LINE_W / BLK - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (accept && last_pix) state_d = ST_DRAIN;
            ST_DRAIN: if (xfer && last_blk)   state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // Handshake outputs are forced low while reset is held, independent of state.
    always_comb begin
        bus.o_in_ready  = 1'b0;
        bus.o_blk_valid = 1'b0;
        case (state_q)
            ST_FILL:  bus.o_in_ready  = !i_rst;
            ST_DRAIN: bus.o_blk_valid = !i_rst;
            default:  ;
        endcase
        bus.o_blk_last = bus.o_blk_valid && last_blk;
    end

    // Counters wrap naturally: a full band returns col, line and block index to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_cnt  <= '0;
            line_cnt <= '0;
            blk_idx  <= '0;
        end else begin
            if (accept) begin
                col_cnt <= col_cnt + 1'b1;
                if (last_col) line_cnt <= line_cnt + 1'b1;
            end
            if (xfer) blk_idx <= blk_idx + 1'b1;
        end
    end

    assign bus.o_blk_idx = blk_idx;

    always_comb begin
        wr_en = '0;
        if (accept) wr_en[line_cnt] = 1'b1;
    end

    for (genvar g = 0; g < BLK; g++) begin : g_line
        dct_block_ctrl_line_buf u_line_buf (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .wr_en   (wr_en[g]),
            .wr_data (bus.i_pix),
            .rd_en   (xfer),
            .rd_data (rows[g])
        );
        assign bus.o_block[g*ROW_W +: ROW_W] = rows[g];
    end

endmodule

// File: tb/tb_dct_block_ctrl.sv
// Self-checking bench for dct_block_ctrl against a band-image reference model.
module tb_dct_block_ctrl;
    import dct_block_ctrl_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    dct_block_ctrl_if bus ();

    dct_block_ctrl #(.LINE_W(256), .BLK(8)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference image of the band currently held: img[line][col].
    logic [7:0] img [8][256];
    int         n_acc;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [511:0] exp_block(input int k);
        logic [511:0] b;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[64*r + 8*c +: 8] = img[r][8*k + c];
        return b;
    endfunction

    // Asserts reset from the current point for the given number of clock edges.
    task automatic reset_dut(input int cycles);
        i_rst           = 1'b1;
        bus.i_pix_valid = 1'b0;
        bus.i_blk_ready = 1'b0;
        bus.i_pix       = '0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check("rst_in_ready", bus.o_in_ready, 0);
            check("rst_blk_valid", bus.o_blk_valid, 0);
            check("rst_blk_last", bus.o_blk_last, 0);
            @(negedge i_clk);
        end
        i_rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.o_in_ready, 1);
        check("post_rst_blk_valid", bus.o_blk_valid, 0);
        check("post_rst_blk_idx", bus.o_blk_idx, 0);
        n_acc = 0;
    endtask

    // mode 0: {line[2:0], col[7:3]}; mode 1: random data, valid toggling; mode 2: constant 0xA5.
    task automatic feed(input int n_pix, input int mode);
        int  budget;
        bit  tog;
        int  line, col;
        logic [7:0] pix;
        budget = 0;
        tog    = 1'b1;
        n_acc  = 0;
        while (n_acc < n_pix && budget < 10000) begin
            @(negedge i_clk);
            budget++;
            check("fill_in_ready", bus.o_in_ready, 1);
            check("fill_blk_valid", bus.o_blk_valid, 0);
            line = n_acc / 256;
            col  = n_acc % 256;
            case (mode)
                0:       pix = 8'(((line & 7) << 5) | (col >> 3));
                1:       pix = 8'($urandom);
                default: pix = 8'hA5;
            endcase
            bus.i_blk_ready = 1'($urandom);
            bus.i_pix       = (mode == 1 && !tog) ? 8'($urandom) : pix;
            bus.i_pix_valid = (mode == 1) ? tog : 1'b1;
            if (bus.i_pix_valid) begin
                img[line][col] = pix;
                n_acc++;
            end
            tog = !tog;
        end
        if (n_acc < n_pix) check("fill_timeout", 0, 1);
    endtask

    // Consumes blocks until 32 transfers, optionally stalling, randomizing ready,
    // driving pixels during drain, or resetting when block rst_at is presented.
    task automatic drain(input int stall_at, input int stall_len, input bit rand_ready,
                         input bit pix_during, input int rst_at, input bit pat);
        int k, stall, budget;
        bit first, ready;
        k = 0; stall = 0; budget = 0; first = 1'b1;
        while (k < 32 && budget < 2000) begin
            @(negedge i_clk);
            budget++;
            if (k == rst_at) begin
                reset_dut(2);
                return;
            end
            if (first) begin
                check("drain_latency", bus.o_blk_valid, 1);
                first = 1'b0;
            end
            check("drain_in_ready", bus.o_in_ready, 0);
            check("drain_blk_valid", bus.o_blk_valid, 1);
            check("blk_idx", bus.o_blk_idx, 512'(k));
            check("blk_last", bus.o_blk_last, 512'(k == 31));
            check("blk_data", bus.o_block, exp_block(k));
            if (pat && k == 5) check("blk5_row3", bus.o_block[3*64 +: 8], 8'h65);
            if (k == stall_at && stall < stall_len) begin
                ready = 1'b0;
                stall++;
            end else if (rand_ready) begin
                ready = 1'($urandom);
            end else begin
                ready = 1'b1;
            end
            bus.i_blk_ready = ready;
            bus.i_pix_valid = pix_during;
            bus.i_pix       = 8'($urandom);
            if (ready) k++;
        end
        if (k < 32) check("drain_timeout", 0, 1);
        @(negedge i_clk);
        bus.i_pix_valid = 1'b0;
        check("refill_in_ready", bus.o_in_ready, 1);
        check("refill_blk_valid", bus.o_blk_valid, 0);
        check("refill_blk_idx", bus.o_blk_idx, 0);
    endtask

    initial begin
        i_rst           = 1'b1;
        bus.i_pix       = '0;
        bus.i_pix_valid = 1'b0;
        bus.i_blk_ready = 1'b0;
        reset_dut(3);

        // Full band, free-flowing downstream.
        feed(2048, 0);
        drain(-1, 0, 1'b0, 1'b0, -1, 1'b1);

        // Backpressure at block 4 for 10 cycles.
        feed(2048, 0);
        drain(4, 10, 1'b0, 1'b0, -1, 1'b1);

        // Two back-to-back bubbly bands, pixels offered throughout drain.
        feed(2048, 1);
        drain(-1, 0, 1'b1, 1'b1, -1, 1'b0);
        feed(2048, 1);
        drain(-1, 0, 1'b1, 1'b1, -1, 1'b0);

        // Reset at block 10, then a constant band.
        feed(2048, 0);
        drain(-1, 0, 1'b0, 1'b0, 10, 1'b1);
        feed(2048, 2);
        drain(-1, 0, 1'b0, 1'b0, -1, 1'b0);

        // Reset mid-fill discards the partial band.
        feed(300, 1);
        @(negedge i_clk);
        reset_dut(2);
        feed(2048, 0);
        drain(-1, 0, 1'b1, 1'b0, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
